fetch_req_queue: RTL and testbench

- Parametrised successor to the single-outstanding pre-IF stage.
- Generates fetch PCs and issues block-aligned icache requests, with up to DEPTH requests in flight.
- Pairs in-order icache responses with their recorded PCs and presents FETCH_WIDTH-instruction blocks to IF over a valid/ready handshake.
- On redirect, responses still in flight are counted and silently discarded.

---
 rtl/fetch_req_queue.sv | 238 +++++++++++++++++++++++
 tb/tb_fetch_req_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_req_queue.sv
`default_nettype none
//============================================================================
// Module   : fetch_req_queue
// Purpose  : Pre-IF fetch stage with up to DEPTH icache requests in flight.
//            Generates sequential fetch PCs and issues block-aligned icache
//            requests. Responses come back in order and are paired with the
//            PC recorded at issue time. The resulting FETCH_WIDTH-instruction
//            blocks go to IF over a valid/ready handshake. After a redirect,
//            responses still in flight are counted and silently discarded.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters
//   DEPTH       : max entries (outstanding + buffered + pending-cancel), 2^n, >=2
//   FETCH_WIDTH : instructions per fetch block, 2^n, 1..4
//   RESET_PC    : first fetch PC after reset
// Ports
//   clk, reset                  : clock, synchronous active-high reset
//   redirect_valid/redirect_pc  : flush / mispredict / eret redirect
//   icache_req/icache_addr      : block-aligned request, held until addr_ok
//   icache_addr_ok              : request accepted this cycle
//   icache_data_ok/icache_rdata : in-order response, inst i at [32i+31:32i]
//   fs_valid/fs_ready           : block handshake towards IF
//   fs_pc/fs_inst/fs_mask       : PC of first valid inst, block data, slot mask
//   fs_adel                     : address-error entry (inst = 0, mask = 0)
// Optional build macro
//   FETCH_PERF_CNT_EN : adds saturating counters perf_cancelled / perf_stall
//============================================================================
module fetch_req_queue #(
    parameter int          DEPTH       = 4,
    parameter int          FETCH_WIDTH = 2,
    parameter logic [31:0] RESET_PC    = 32'hbfc00000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    output logic                      icache_req,
    output logic [31:0]               icache_addr,
    input  logic                      icache_addr_ok,
    input  logic                      icache_data_ok,
    input  logic [32*FETCH_WIDTH-1:0] icache_rdata,
    output logic                      fs_valid,
    input  logic                      fs_ready,
    output logic [31:0]               fs_pc,
    output logic [32*FETCH_WIDTH-1:0] fs_inst,
    output logic [FETCH_WIDTH-1:0]    fs_mask,
    output logic                      fs_adel
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]               perf_cancelled,
    output logic [31:0]               perf_stall
`endif
);

    localparam int                BLK      = FETCH_WIDTH * 4;
    localparam int                OFF_W    = $clog2(BLK);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = $clog2(DEPTH + 1);
    localparam int                DW       = 32 * FETCH_WIDTH;
    localparam logic [31:0]       BLK_MASK = ~(32'(BLK) - 32'd1);
    localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Queue storage (circular buffer)
    // ------------------------------------------------------------------
    logic [31:0]      q_pc      [DEPTH];
    logic [DW-1:0]    q_data    [DEPTH];
    logic [DEPTH-1:0] q_arrived;
    logic [DEPTH-1:0] q_adel;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] occ;          // entries in the queue
    logic [CNT_W-1:0] pend_cnt;     // entries still waiting for data
    logic [CNT_W-1:0] cancel_cnt;   // in-flight responses to discard
    logic [31:0]      pc;
    logic             halted;

    // ------------------------------------------------------------------
    // Issue / push / pop decisions
    // ------------------------------------------------------------------
    logic [CNT_W:0]   used;
    logic             space;
    logic             fetch_ok;
    logic             aligned;
    logic             req_push;
    logic             adel_push;
    logic             push;
    logic             pop;
    logic             drop;
    logic             fill;
    logic [PTR_W-1:0] fill_idx;
    logic [CNT_W:0]   redir_cancel;

    assign used     = {1'b0, occ} + {1'b0, cancel_cnt};
    assign space    = used < DEPTH_C;
    assign fetch_ok = !reset && !halted && !redirect_valid;
    assign aligned  = (pc[1:0] == 2'b00);

    assign icache_req  = fetch_ok && aligned && space;
    assign icache_addr = pc & BLK_MASK;

    assign req_push  = icache_req && icache_addr_ok;
    // A misaligned PC becomes a pre-arrived error entry and stops fetch.
    assign adel_push = fetch_ok && !aligned && space;
    assign push      = req_push || adel_push;

    // Responses owed to pre-redirect requests are consumed first.
    assign drop = icache_data_ok && (cancel_cnt != '0);
    assign fill = icache_data_ok && (cancel_cnt == '0) && (pend_cnt != '0);

    // Pending entries are always the youngest ones, so the oldest one
    // waiting for data sits pend_cnt slots behind the tail.
    assign fill_idx = tail - PTR_W'(pend_cnt);

    assign fs_valid = !reset && (occ != '0) && q_arrived[head];
    // A pop coinciding with a redirect is ignored; the queue is flushed.
    assign pop      = fs_valid && fs_ready && !redirect_valid;

    // On redirect every response still owed becomes a cancel: the old
    // cancels, the entries without data, and an acceptance in this very
    // cycle. A same-cycle response is taken off first (it was either a
    // cancel or filled an entry that is now discarded).
    assign redir_cancel = {1'b0, cancel_cnt} + {1'b0, pend_cnt}
                        + (CNT_W + 1)'(icache_addr_ok)
                        - (CNT_W + 1)'(drop || fill);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            halted     <= 1'b0;
            occ        <= '0;
            pend_cnt   <= '0;
            cancel_cnt <= '0;
            head       <= '0;
            tail       <= '0;
        end else if (redirect_valid) begin
            pc         <= redirect_pc;
            halted     <= 1'b0;
            occ        <= '0;
            pend_cnt   <= '0;
            cancel_cnt <= CNT_W'(redir_cancel);
            head       <= '0;
            tail       <= '0;
        end else begin
            if (req_push) begin
                pc <= icache_addr + 32'(BLK);
            end
            if (adel_push) begin
                halted <= 1'b1;
            end
            occ      <= occ + CNT_W'(push) - CNT_W'(pop);
            pend_cnt <= pend_cnt + CNT_W'(req_push) - CNT_W'(fill);
            if (drop) begin
                cancel_cnt <= cancel_cnt - 1'b1;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry storage; contents are meaningless while occ says the slot is
    // free, so no reset is needed. A push never targets the slot being
    // filled because a push requires a free slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]      <= pc;
            q_data[tail]    <= '0;
            q_arrived[tail] <= adel_push;
            q_adel[tail]    <= adel_push;
        end
        if (fill) begin
            q_data[fill_idx]    <= icache_rdata;
            q_arrived[fill_idx] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output block
    // ------------------------------------------------------------------
    logic [31:0] head_pc;
    logic        head_adel;

    assign head_pc   = q_pc[head];
    assign head_adel = q_adel[head];
    assign fs_pc     = head_pc;
    assign fs_inst   = q_data[head];
    assign fs_adel   = head_adel;

    generate
        if (FETCH_WIDTH == 1) begin : g_mask_single
            assign fs_mask = !head_adel;
        end else begin : g_mask_multi
            localparam int SLOT_W = OFF_W - 2;
            logic [SLOT_W-1:0] first_slot;
            // Slots before the PC's word offset inside the block are skipped.
            assign first_slot = head_pc[OFF_W-1:2];
            for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
                assign fs_mask[i] = !head_adel && (SLOT_W'(i) >= first_slot);
            end
        end
    endgenerate

`ifdef FETCH_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic stall_full;

    // Would have requested, but the queue (including cancels) is full.
    assign stall_full = fetch_ok && aligned && !space;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cancelled <= '0;
            perf_stall     <= '0;
        end else begin
            if (drop && (perf_cancelled != 32'hffff_ffff)) begin
                perf_cancelled <= perf_cancelled + 32'd1;
            end
            if (stall_full && (perf_stall != 32'hffff_ffff)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_req_queue.sv
`default_nettype none
//============================================================================
// Module   : tb_fetch_req_queue
// Purpose  : Self-checking bench for fetch_req_queue (DEPTH=4, FETCH_WIDTH=2).
//            Cycle vectors hold the inputs for one cycle plus the outputs
//            expected in that cycle; a hand-written sequence covers
//            back-to-back redirects.
// Revision : 1.0 - initial release
//============================================================================
module tb_fetch_req_queue;

    localparam int          FW = 2;
    localparam logic [31:0] B  = 32'hbfc00000;
    localparam logic [63:0] ST = 64'hdead_beef_dead_beef;

    logic            clk;
    logic            reset;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            icache_req;
    logic [31:0]     icache_addr;
    logic            icache_addr_ok;
    logic            icache_data_ok;
    logic [32*FW-1:0] icache_rdata;
    logic            fs_valid;
    logic            fs_ready;
    logic [31:0]     fs_pc;
    logic [32*FW-1:0] fs_inst;
    logic [FW-1:0]   fs_mask;
    logic            fs_adel;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     perf_cancelled;
    logic [31:0]     perf_stall;
`endif

    fetch_req_queue #(
        .DEPTH       (4),
        .FETCH_WIDTH (FW),
        .RESET_PC    (B)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_addr_ok (icache_addr_ok),
        .icache_data_ok (icache_data_ok),
        .icache_rdata   (icache_rdata),
        .fs_valid       (fs_valid),
        .fs_ready       (fs_ready),
        .fs_pc          (fs_pc),
        .fs_inst        (fs_inst),
        .fs_mask        (fs_mask),
        .fs_adel        (fs_adel)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_cancelled (perf_cancelled),
        .perf_stall     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        aok;
        logic        dok;
        logic [63:0] rdat;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [1:0]  mask;
        logic        adel;
        logic [63:0] inst;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] d(input int n);
        return {32'hc0de0000 + 32'(n), 32'h51100000 + 32'(n)};
    endfunction

    function automatic void add(input logic rst, rv, input logic [31:0] rpc,
                                input logic aok, dok, input logic [63:0] rdat,
                                input logic rdy, req, input logic [31:0] addr,
                                input logic vld, input logic [31:0] pc,
                                input logic [1:0] mask, input logic adel,
                                input logic [63:0] inst);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.aok = aok; v.dok = dok;
        v.rdat = rdat; v.rdy = rdy; v.req = req; v.addr = addr; v.vld = vld;
        v.pc = pc; v.mask = mask; v.adel = adel; v.inst = inst;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic r, rv, input logic [31:0] rpc,
                         input logic aok, dok, input logic [63:0] rd, input logic rdy);
        @(negedge clk);
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        icache_addr_ok = aok;
        icache_data_ok = dok;
        icache_rdata   = rd;
        fs_ready       = rdy;
        #1;
    endtask

    initial begin
        vec_t v;
        logic found;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        icache_addr_ok = 1'b0; icache_data_ok = 1'b0; icache_rdata = '0; fs_ready = 1'b0;

        //   rst rv rpc           aok dok rdat   rdy req addr          vld pc            mask   adel inst
        // reset and sequential streaming
        add(1, 0, 0,            0, 0, 0,     0,  0, 0,            0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 0, 0,     1,  1, B,            0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 0, 0,     0,  1, B+32'h08,     0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 1, d(0),  0,  1, B+32'h10,     0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 1, d(1),  1,  1, B+32'h18,     1, B,            2'b11, 0, d(0));
        add(0, 0, 0,            1, 1, d(2),  1,  1, B+32'h20,     1, B+32'h08,     2'b11, 0, d(1));
        add(0, 0, 0,            0, 1, d(3),  1,  1, B+32'h28,     1, B+32'h10,     2'b11, 0, d(2));
        add(0, 0, 0,            0, 1, d(4),  1,  1, B+32'h28,     1, B+32'h18,     2'b11, 0, d(3));
        add(0, 0, 0,            0, 0, 0,     1,  1, B+32'h28,     1, B+32'h20,     2'b11, 0, d(4));
        add(0, 0, 0,            0, 0, 0,     0,  1, B+32'h28,     0, 0,            2'b00, 0, 0);
        // fill to DEPTH with IF stalled, one pop frees one request
        add(0, 0, 0,            1, 0, 0,     0,  1, B+32'h28,     0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 0, 0,     0,  1, B+32'h30,     0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 1, d(10), 0,  1, B+32'h38,     0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 1, d(11), 0,  1, B+32'h40,     1, B+32'h28,     2'b11, 0, d(10));
        add(0, 0, 0,            1, 1, d(12), 0,  0, 0,            1, B+32'h28,     2'b11, 0, d(10));
        add(0, 0, 0,            0, 1, d(13), 1,  0, 0,            1, B+32'h28,     2'b11, 0, d(10));
        add(0, 0, 0,            1, 0, 0,     0,  1, B+32'h48,     1, B+32'h30,     2'b11, 0, d(11));
        add(0, 0, 0,            0, 0, 0,     0,  0, 0,            1, B+32'h30,     2'b11, 0, d(11));
        // redirect with one pending: head still visible, pop ignored
        add(0, 1, 32'h80001004, 0, 0, 0,     1,  0, 0,            1, B+32'h30,     2'b11, 0, d(11));
        add(0, 0, 0,            1, 0, 0,     1,  1, 32'h80001000, 0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 1, ST,    1,  1, 32'h80001008, 0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 0, 0,     1,  1, 32'h80001010, 0, 0,            2'b00, 0, 0);
        // redirect with 3 outstanding: cancel_cnt=3 limits issue to one
        add(0, 1, 32'h80001004, 0, 0, 0,     0,  0, 0,            0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 0, 0,     0,  1, 32'h80001000, 0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 1, ST,    0,  0, 0,            0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            0, 1, ST,    0,  1, 32'h80001008, 0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            0, 1, ST,    0,  1, 32'h80001008, 0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            0, 1, d(20), 0,  1, 32'h80001008, 0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            0, 0, 0,     1,  1, 32'h80001008, 1, 32'h80001004, 2'b10, 0, d(20));
        add(0, 0, 0,            0, 0, 0,     1,  1, 32'h80001008, 0, 0,            2'b00, 0, 0);
        // redirect coinciding with addr_ok and data_ok of an older request
        add(0, 0, 0,            1, 0, 0,     0,  1, 32'h80001008, 0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 0, 0,     0,  1, 32'h80001010, 0, 0,            2'b00, 0, 0);
        add(0, 1, 32'h80002000, 1, 1, d(30), 0,  0, 0,            0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            0, 1, ST,    0,  1, 32'h80002000, 0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            0, 1, ST,    0,  1, 32'h80002000, 0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 0, 0,     0,  1, 32'h80002000, 0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            0, 1, d(31), 0,  1, 32'h80002008, 0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            0, 0, 0,     1,  1, 32'h80002008, 1, 32'h80002000, 2'b11, 0, d(31));
        // misaligned redirect: error entry, halt, resume by redirect
        add(0, 1, 32'h80000002, 0, 0, 0,     0,  0, 0,            0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 0, 0,     0,  0, 0,            0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            0, 0, 0,     0,  0, 0,            1, 32'h80000002, 2'b00, 1, 0);
        add(0, 0, 0,            0, 0, 0,     1,  0, 0,            1, 32'h80000002, 2'b00, 1, 0);
        add(0, 0, 0,            0, 0, 0,     1,  0, 0,            0, 0,            2'b00, 0, 0);
        add(0, 1, 32'h80000000, 0, 0, 0,     0,  0, 0,            0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 0, 0,     0,  1, 32'h80000000, 0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            1, 0, 0,     0,  1, 32'h80000008, 0, 0,            2'b00, 0, 0);
        // reset with 2 outstanding
        add(1, 0, 0,            0, 0, 0,     0,  0, 0,            0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            0, 0, 0,     1,  1, B,            0, 0,            2'b00, 0, 0);
        add(0, 0, 0,            0, 0, 0,     1,  1, B,            0, 0,            2'b00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.rst, v.rv, v.rpc, v.aok, v.dok, v.rdat, v.rdy);
            chk($sformatf("v%0d icache_req", i), 64'(icache_req), 64'(v.req));
            chk($sformatf("v%0d fs_valid", i), 64'(fs_valid), 64'(v.vld));
            if (v.req) chk($sformatf("v%0d icache_addr", i), 64'(icache_addr), 64'(v.addr));
            if (v.vld) begin
                chk($sformatf("v%0d fs_pc", i), 64'(fs_pc), 64'(v.pc));
                chk($sformatf("v%0d fs_mask", i), 64'(fs_mask), 64'(v.mask));
                chk($sformatf("v%0d fs_adel", i), 64'(fs_adel), 64'(v.adel));
                chk($sformatf("v%0d fs_inst", i), fs_inst, v.inst);
            end
        end

        // Back-to-back redirects: two outstanding, redirect, then a second
        // redirect in the same cycle as one stale response -> one cancel left.
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("b2b req0", 64'({icache_req, icache_addr}), {31'd0, 1'b1, B});
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("b2b req1", 64'({icache_req, icache_addr}), {31'd0, 1'b1, B + 32'h08});
        drive(0, 1, 32'h80003000, 0, 0, 0, 0);
        chk("b2b redir1 req", 64'(icache_req), 64'd0);
        drive(0, 1, 32'h80004000, 0, 1, ST, 0);
        chk("b2b redir2 req", 64'(icache_req), 64'd0);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("b2b new req", 64'({icache_req, icache_addr}), {31'd0, 1'b1, 32'h80004000});
        drive(0, 0, 0, 0, 1, ST, 0);
        chk("b2b stale dropped", 64'(fs_valid), 64'd0);
        drive(0, 0, 0, 0, 1, d(40), 0);
        chk("b2b before fill", 64'(fs_valid), 64'd0);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            if (fs_valid) begin
                found = 1'b1;
                chk("b2b fs_pc", 64'(fs_pc), 64'h80004000);
                chk("b2b fs_inst", fs_inst, d(40));
                chk("b2b fs_mask", 64'(fs_mask), 64'd3);
            end
        end
        chk("b2b block delivered", 64'(found), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("b2b drained", 64'(fs_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
